// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the staged reset-release sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN,
    ERR
  } seq_state_t;

  // One counter serves both the hold window and the ack timeout, so it is sized for the larger.
  function automatic int cnt_width(input int hold, input int timeout);
    return $clog2((hold > timeout) ? hold : timeout) + 1;
  endfunction

endpackage

// File: rtl/reset_seq_cnt.sv
// Shared up-counter with clear, enable and equality terminal-count flag.
// Latency: count visible the cycle after enable; no backpressure, clear wins over enable.
module reset_seq_cnt
  import reset_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

  assign tc_o = (cnt_o == term_i);

endmodule

// File: rtl/reset_seq.sv
// Staged reset-release sequencer: holds all domains, then releases one per acknowledged stage.
// Latency: stage 0 releases HOLD_CYCLES low req samples after entry; req_i always overrides.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_i,
  input  logic [NUM_STAGES-1:0]         ack_i,
  output logic [NUM_STAGES-1:0]         stage_rst_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [$clog2(NUM_STAGES):0]   err_stage_o
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, TIMEOUT);
  localparam int IDX_W = $clog2(NUM_STAGES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  seq_state_t              state;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        nxt_idx;
  logic [NUM_STAGES-1:0]   rel_mask;
  logic                    ack_cur;
  logic                    cnt_clr;
  logic                    cnt_en;
  logic                    cnt_tc;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_term;

  assign nxt_idx  = idx + 1'b1;
  assign cnt_term = (state == HOLD) ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(TIMEOUT - 1);

  // Only the ack of the stage currently being released is observed.
  always_comb begin
    ack_cur  = 1'b0;
    rel_mask = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (IDX_W'(k) == idx)      ack_cur     = ack_i[k];
      if (IDX_W'(k) <= nxt_idx)  rel_mask[k] = 1'b1;
    end
  end

  always_comb begin
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
    if (!req_i) begin
      case (state)
        HOLD: begin
          cnt_clr = cnt_tc;
          cnt_en  = !cnt_tc;
        end
        RELEASE: begin
          cnt_clr = ack_cur || cnt_tc;
          cnt_en  = !(ack_cur || cnt_tc);
        end
        default: ;
      endcase
    end
  end

  reset_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (cnt_term),
    .cnt_o  (cnt),
    .tc_o   (cnt_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= HOLD;
      idx         <= '0;
      stage_rst_o <= '1;
      busy_o      <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_stage_o <= '0;
    end else if (req_i) begin
      state       <= HOLD;
      idx         <= '0;
      stage_rst_o <= '1;
      busy_o      <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_stage_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        HOLD: begin
          stage_rst_o <= '1;
          busy_o      <= 1'b1;
          if (cnt_tc) begin
            state       <= RELEASE;
            idx         <= '0;
            stage_rst_o <= ~NUM_STAGES'(1);
          end
        end
        RELEASE: begin
          // An ack on the terminal-count edge still counts as success.
          if (ack_cur) begin
            if (idx == LAST_IDX) begin
              state       <= RUN;
              stage_rst_o <= '0;
              done_o      <= 1'b1;
              busy_o      <= 1'b0;
            end else begin
              idx         <= nxt_idx;
              stage_rst_o <= ~rel_mask;
            end
          end else if (cnt_tc) begin
            state       <= ERR;
            stage_rst_o <= '1;
            err_o       <= 1'b1;
            err_stage_o <= idx;
          end
        end
        RUN: begin
          stage_rst_o <= '0;
          busy_o      <= 1'b0;
        end
        ERR: begin
          stage_rst_o <= '1;
          busy_o      <= 1'b1;
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq with NUM_STAGES=3, HOLD_CYCLES=4, TIMEOUT=8.
module tb_reset_seq;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_i;
  logic [2:0] ack_i;
  logic [2:0] stage_rst_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic [2:0] err_stage_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  reset_seq #(.NUM_STAGES(3), .HOLD_CYCLES(4), .TIMEOUT(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .ack_i       (ack_i),
    .stage_rst_o (stage_rst_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_stage_o (err_stage_o)
  );

  always #5 clk_i = ~clk_i;

  // Outputs are read 1 time unit after the edge; inputs changed here are sampled next edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = 1'b0; ack_i = 3'b000;
    tick(); tick();
    total_cnt++; if (stage_rst_o !== 3'b111) $display("FAIL reset_stage: got %b want 111", stage_rst_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy_o); else pass_cnt++;
    total_cnt++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else pass_cnt++;
    total_cnt++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else pass_cnt++;
    total_cnt++; if (err_stage_o !== 3'd0) $display("FAIL reset_err_stage: got %0d want 0", err_stage_o); else pass_cnt++;
    rst_i = 1'b0;
  endtask

  task automatic test_nominal();
    logic [2:0] exp_before [3] = '{3'b110, 3'b100, 3'b000};
    logic [2:0] exp_after  [3] = '{3'b100, 3'b000, 3'b000};
    for (int i = 1; i <= 3; i++) begin
      tick();
      total_cnt++; if (stage_rst_o !== 3'b111) $display("FAIL nom_hold%0d: got %b want 111", i, stage_rst_o); else pass_cnt++;
    end
    tick();
    total_cnt++; if (stage_rst_o !== 3'b110) $display("FAIL nom_rel0: got %b want 110", stage_rst_o); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++; if (stage_rst_o !== exp_before[k] || done_o !== 1'b0)
        $display("FAIL nom_wait%0d: got %b/%b want %b/0", k, stage_rst_o, done_o, exp_before[k]); else pass_cnt++;
      ack_i[k] = 1'b1;
      tick();
      total_cnt++; if (stage_rst_o !== exp_after[k]) $display("FAIL nom_ack%0d: got %b want %b", k, stage_rst_o, exp_after[k]); else pass_cnt++;
    end
    total_cnt++; if (done_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL nom_done: got done=%b busy=%b want 1/0", done_o, busy_o); else pass_cnt++;
    ack_i = 3'b000;
    tick();
    total_cnt++; if (done_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL nom_done_pulse: got done=%b busy=%b want 0/0", done_o, busy_o); else pass_cnt++;
    total_cnt++; if (stage_rst_o !== 3'b000) $display("FAIL nom_run_ack_drop: got %b want 000", stage_rst_o); else pass_cnt++;
  endtask

  task automatic test_reset_override();
    rst_i = 1'b1; req_i = 1'b0;
    tick();
    total_cnt++; if (stage_rst_o !== 3'b111 || busy_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL rst_override: got %b busy=%b done=%b err=%b want 111/1/0/0", stage_rst_o, busy_o, done_o, err_o); else pass_cnt++;
    rst_i = 1'b0;
  endtask

  task automatic test_hold_restart();
    for (int i = 0; i < 3; i++) tick();
    req_i = 1'b1;
    tick();
    total_cnt++; if (stage_rst_o !== 3'b111) $display("FAIL restart_req: got %b want 111", stage_rst_o); else pass_cnt++;
    req_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    total_cnt++; if (stage_rst_o !== 3'b111) $display("FAIL restart_early: got %b want 111", stage_rst_o); else pass_cnt++;
    tick();
    total_cnt++; if (stage_rst_o !== 3'b110) $display("FAIL restart_rel: got %b want 110", stage_rst_o); else pass_cnt++;
  endtask

  // Runs straight on from the release of stage 0 in test_hold_restart.
  task automatic test_timeout();
    ack_i = 3'b001;
    tick();
    total_cnt++; if (stage_rst_o !== 3'b100) $display("FAIL to_rel1: got %b want 100", stage_rst_o); else pass_cnt++;
    for (int i = 1; i <= 7; i++) begin
      tick();
      total_cnt++; if (stage_rst_o !== 3'b100 || err_o !== 1'b0)
        $display("FAIL to_wait%0d: got %b err=%b want 100/0", i, stage_rst_o, err_o); else pass_cnt++;
    end
    tick();
    total_cnt++; if (stage_rst_o !== 3'b111 || err_o !== 1'b1 || err_stage_o !== 3'd1 || busy_o !== 1'b1)
      $display("FAIL to_err: got %b err=%b stage=%0d busy=%b want 111/1/1/1", stage_rst_o, err_o, err_stage_o, busy_o); else pass_cnt++;
    ack_i = 3'b111;
    for (int i = 0; i < 3; i++) tick();
    total_cnt++; if (err_o !== 1'b1 || stage_rst_o !== 3'b111) $display("FAIL to_err_hold: got err=%b %b want 1/111", err_o, stage_rst_o); else pass_cnt++;
    req_i = 1'b1; ack_i = 3'b000;
    tick();
    total_cnt++; if (err_o !== 1'b0 || err_stage_o !== 3'd0 || stage_rst_o !== 3'b111 || busy_o !== 1'b1)
      $display("FAIL to_clear: got err=%b stage=%0d %b busy=%b want 0/0/111/1", err_o, err_stage_o, stage_rst_o, busy_o); else pass_cnt++;
    req_i = 1'b0;
  endtask

  task automatic test_mid_request();
    for (int i = 0; i < 4; i++) tick();
    total_cnt++; if (stage_rst_o !== 3'b110) $display("FAIL mid_rel0: got %b want 110", stage_rst_o); else pass_cnt++;
    ack_i = 3'b001;
    tick();
    total_cnt++; if (stage_rst_o !== 3'b100) $display("FAIL mid_rel1: got %b want 100", stage_rst_o); else pass_cnt++;
    req_i = 1'b1; ack_i = 3'b000;
    tick();
    total_cnt++; if (stage_rst_o !== 3'b111 || done_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL mid_req: got %b done=%b busy=%b want 111/0/1", stage_rst_o, done_o, busy_o); else pass_cnt++;
    req_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    total_cnt++; if (stage_rst_o !== 3'b111) $display("FAIL mid_rerun_hold: got %b want 111", stage_rst_o); else pass_cnt++;
    tick();
    ack_i = 3'b001; tick();
    ack_i = 3'b011; tick();
    total_cnt++; if (stage_rst_o !== 3'b000 || done_o !== 1'b0) $display("FAIL mid_rerun_rel2: got %b done=%b want 000/0", stage_rst_o, done_o); else pass_cnt++;
    ack_i = 3'b111; tick();
    total_cnt++; if (done_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL mid_rerun_done: got done=%b busy=%b want 1/0", done_o, busy_o); else pass_cnt++;
    ack_i = 3'b000;
  endtask

  task automatic test_ack_timeout_tie();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    ack_i = 3'b001; tick();
    ack_i = 3'b011; tick();
    total_cnt++; if (stage_rst_o !== 3'b000) $display("FAIL tie_rel2: got %b want 000", stage_rst_o); else pass_cnt++;
    for (int i = 0; i < 7; i++) tick();
    total_cnt++; if (done_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL tie_pre: got done=%b err=%b busy=%b want 0/0/1", done_o, err_o, busy_o); else pass_cnt++;
    ack_i = 3'b111; tick();
    total_cnt++; if (done_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0 || stage_rst_o !== 3'b000)
      $display("FAIL tie_edge: got done=%b err=%b busy=%b %b want 1/0/0/000", done_o, err_o, busy_o, stage_rst_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reset_override();
    test_hold_restart();
    test_timeout();
    test_mid_request();
    test_ack_timeout_tie();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
